fetch_queue_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_queue.sv | 90 +++++++++
 rtl/fetch_queue_stage.sv | 103 ++++++++++
 tb/tb_fetch_queue_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the decoupled fetch queue stage.
package fetch_pkg;

    localparam int          FETCH_XLEN     = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam int          INSTR_BYTES    = 4;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
        logic                  filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are allocated at request, filled at response
// and popped by decode. Three pointers carry one extra wrap bit each.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int XLEN  = FETCH_XLEN,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       alloc,
    input  logic [XLEN-1:0]            alloc_pc,
    input  logic                       fill,
    input  logic [31:0]                fill_instr,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [XLEN-1:0]            head_pc,
    output logic [31:0]                head_instr,
    output logic [$clog2(DEPTH):0]     allocated,
    output logic [$clog2(DEPTH):0]     unfilled
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            filled;
    } entry_t;

    entry_t        entries_q [DEPTH];
    entry_t        entries_d [DEPTH];
    logic [AW:0]   alloc_ptr_q, alloc_ptr_d;
    logic [AW:0]   fill_ptr_q,  fill_ptr_d;
    logic [AW:0]   pop_ptr_q,   pop_ptr_d;

    assign allocated  = alloc_ptr_q - pop_ptr_q;
    assign unfilled   = alloc_ptr_q - fill_ptr_q;
    assign head_valid = (allocated != '0) && entries_q[pop_ptr_q[AW-1:0]].filled;
    assign head_pc    = entries_q[pop_ptr_q[AW-1:0]].pc;
    assign head_instr = entries_q[pop_ptr_q[AW-1:0]].instr;

    always_comb begin
        entries_d   = entries_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        pop_ptr_d   = pop_ptr_q;
        if (flush) begin
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            pop_ptr_d   = '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].filled = 1'b0;
            end
        end else begin
            // The tail slot is free whenever alloc is granted, so it never aliases the fill slot.
            if (alloc) begin
                entries_d[alloc_ptr_q[AW-1:0]].pc     = alloc_pc;
                entries_d[alloc_ptr_q[AW-1:0]].filled = 1'b0;
                alloc_ptr_d = alloc_ptr_q + (AW+1)'(1);
            end
            if (fill) begin
                entries_d[fill_ptr_q[AW-1:0]].instr  = fill_instr;
                entries_d[fill_ptr_q[AW-1:0]].filled = 1'b1;
                fill_ptr_d = fill_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                pop_ptr_d = pop_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            pop_ptr_q   <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            pop_ptr_q   <= pop_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage with request/response memory handshake, credit-gated issue and
// redirect flush that drops responses still owed to squashed requests.
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_b_taken,
    input  logic [XLEN-1:0]  e_alu_y,
    output logic             mem_i_req_valid,
    input  logic             mem_i_req_ready,
    output logic [XLEN-1:0]  mem_i_ra,
    input  logic             mem_i_rsp_valid,
    input  logic [31:0]      mem_i_rd,
    output logic             f_valid,
    input  logic             d_ready,
    output logic [31:0]      instr,
    output logic [XLEN-1:0]  pc
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW:0]     drop_cnt_q, drop_cnt_d;
    logic [AW:0]     allocated, unfilled;
    logic [AW+1:0]   credit;
    logic            req_fire, rsp_drop, fill, pop, head_valid;
    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_instr;
    logic            unused_target_lo;

    assign unused_target_lo = ^e_alu_y[1:0];

    // Credits cover both live entries and responses still owed to flushed requests.
    assign credit          = {1'b0, allocated} + {1'b0, drop_cnt_q};
    assign mem_i_req_valid = !reset && !e_b_taken && (credit < (AW+2)'(DEPTH));
    assign mem_i_ra        = fetch_pc_q;
    assign req_fire        = mem_i_req_valid && mem_i_req_ready;
    assign rsp_drop        = mem_i_rsp_valid && (drop_cnt_q != '0);
    assign fill            = mem_i_rsp_valid && !rsp_drop && !e_b_taken;

    assign f_valid = head_valid && !e_b_taken && !reset;
    assign pop     = f_valid && d_ready;
    assign instr   = f_valid ? head_instr : '0;
    assign pc      = f_valid ? head_pc : '0;

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (e_b_taken),
        .alloc      (req_fire),
        .alloc_pc   (fetch_pc_q),
        .fill       (fill),
        .fill_instr (mem_i_rd),
        .pop        (pop),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .allocated  (allocated),
        .unfilled   (unfilled)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (e_b_taken) begin
            fetch_pc_d = {e_alu_y[XLEN-1:2], 2'b00};
            drop_cnt_d = drop_cnt_q + unfilled - (AW+1)'(mem_i_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_i_rsp_valid) begin
            assert (drop_cnt_q != '0 || unfilled != '0)
                else $error("fetch_queue_stage: response with no pending request");
        end
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage with a fixed-latency in-order memory model.
module tb_fetch_queue_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_b_taken;
    logic [31:0] e_alu_y;
    logic        mem_i_req_valid;
    logic        mem_i_req_ready;
    logic [31:0] mem_i_ra;
    logic        mem_i_rsp_valid;
    logic [31:0] mem_i_rd;
    logic        f_valid;
    logic        d_ready;
    logic [31:0] instr;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    int cyc    = 0;
    int fires  = 0;

    logic [31:0] mq_addr[$];
    int          mq_due[$];

    fetch_queue_stage #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .e_b_taken       (e_b_taken),
        .e_alu_y         (e_alu_y),
        .mem_i_req_valid (mem_i_req_valid),
        .mem_i_req_ready (mem_i_req_ready),
        .mem_i_ra        (mem_i_ra),
        .mem_i_rsp_valid (mem_i_rsp_valid),
        .mem_i_rd        (mem_i_rd),
        .f_valid         (f_valid),
        .d_ready         (d_ready),
        .instr           (instr),
        .pc              (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory: request accepted at edge c is presented during the cycle after edge c+lat-1.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mq_addr.delete();
            mq_due.delete();
            fires = 0;
        end else begin
            if (mem_i_rsp_valid) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (mem_i_req_valid && mem_i_req_ready) begin
                mq_addr.push_back(mem_i_ra);
                mq_due.push_back(cyc + lat - 1);
                fires++;
            end
        end
        #1;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            mem_i_rsp_valid = 1'b1;
            mem_i_rd        = instr_of(mq_addr[0]);
        end else begin
            mem_i_rsp_valid = 1'b0;
            mem_i_rd        = NOP_INSTR;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; e_b_taken = 1'b0; e_alu_y = '0; d_ready = 1'b0; mem_i_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_first_out(input string tag, input logic [31:0] exp_pc);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); #1;
            if (f_valid) got = 1'b1;
        end
        chk({tag, "_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, "_pc"}, 64'(pc), 64'(exp_pc));
            chk({tag, "_instr"}, 64'(instr), 64'(instr_of(exp_pc)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_out, exp_req, prev_ra;
        logic        prev_v, prev_r;

        reset = 1'b1; e_b_taken = 1'b0; e_alu_y = '0; mem_i_req_ready = 1'b1;
        d_ready = 1'b0; mem_i_rsp_valid = 1'b0; mem_i_rd = NOP_INSTR;

        // Reset state
        repeat (2) @(negedge clk); #1;
        chk("rst_req_valid", 64'(mem_i_req_valid), 64'd0);
        chk("rst_f_valid", 64'(f_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_ra", 64'(mem_i_ra), 64'h0);

        // Zero-wait memory, decode always ready
        lat = 1;
        apply_reset();
        d_ready = 1'b1; #1;
        chk("s1_req_valid", 64'(mem_i_req_valid), 64'd1);
        chk("s1_ra0", 64'(mem_i_ra), 64'h0);
        @(negedge clk); #1;
        chk("s1_ra1", 64'(mem_i_ra), 64'h4);
        chk("s1_fv_early", 64'(f_valid), 64'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            chk("s1_fv", 64'(f_valid), 64'd1);
            chk("s1_pc", 64'(pc), 64'(4 * k));
            chk("s1_instr", 64'(instr), 64'(instr_of(32'(4 * k))));
        end

        // Latency 3, decode stalled: exactly four requests then back-pressure
        lat = 3;
        apply_reset(); #1;
        chk("s2_req0", 64'(mem_i_req_valid), 64'd1);
        chk("s2_ra0", 64'(mem_i_ra), 64'h0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); #1;
            chk("s2_req", 64'(mem_i_req_valid), 64'd1);
            chk("s2_ra", 64'(mem_i_ra), 64'(4 * i));
        end
        @(negedge clk); #1;
        chk("s2_full_req", 64'(mem_i_req_valid), 64'd0);
        chk("s2_head_fv", 64'(f_valid), 64'd1);
        repeat (3) @(negedge clk); #1;
        chk("s2_still_full", 64'(mem_i_req_valid), 64'd0);
        chk("s2_fires", 64'(fires), 64'd4);
        chk("s2_pc0", 64'(pc), 64'h0);
        d_ready = 1'b1; #1;
        chk("s2_pop0", 64'(pc), 64'h0);
        @(negedge clk); #1;
        chk("s2_resume_req", 64'(mem_i_req_valid), 64'd1);
        chk("s2_resume_ra", 64'(mem_i_ra), 64'h10);
        exp_out = 32'h4;
        for (int i = 0; i < 20 && exp_out != 32'h14; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            if (f_valid) begin
                chk("s2_order_pc", 64'(pc), 64'(exp_out));
                chk("s2_order_instr", 64'(instr), 64'(instr_of(exp_out)));
                exp_out += 32'h4;
            end
        end
        chk("s2_drained", 64'(exp_out), 64'h14);

        // Redirect to 0x103 with two requests still unfilled
        lat = 3;
        apply_reset();
        @(negedge clk);
        @(negedge clk);
        e_b_taken = 1'b1; e_alu_y = 32'h103; #1;
        chk("s3_redir_req", 64'(mem_i_req_valid), 64'd0);
        chk("s3_redir_fv", 64'(f_valid), 64'd0);
        @(negedge clk);
        e_b_taken = 1'b0; d_ready = 1'b1; #1;
        chk("s3_ra", 64'(mem_i_ra), 64'h100);
        chk("s3_req", 64'(mem_i_req_valid), 64'd1);
        chk("s3_drop2", 64'(dut.drop_cnt_q), 64'd2);
        @(negedge clk); #1;
        chk("s3_drop1", 64'(dut.drop_cnt_q), 64'd1);
        @(negedge clk); #1;
        chk("s3_drop0", 64'(dut.drop_cnt_q), 64'd0);
        wait_first_out("s3_first", 32'h100);

        // Redirect coinciding with a response and a decode pop
        lat = 2;
        apply_reset();
        repeat (3) @(negedge clk); #1;
        chk("s4_pre_fv", 64'(f_valid), 64'd1);
        chk("s4_pre_pc", 64'(pc), 64'h0);
        d_ready = 1'b1; e_b_taken = 1'b1; e_alu_y = 32'h200; #1;
        chk("s4_redir_fv", 64'(f_valid), 64'd0);
        chk("s4_redir_pc", 64'(pc), 64'h0);
        chk("s4_redir_req", 64'(mem_i_req_valid), 64'd0);
        @(negedge clk);
        e_b_taken = 1'b0; #1;
        chk("s4_drop", 64'(dut.drop_cnt_q), 64'd1);
        chk("s4_ra", 64'(mem_i_ra), 64'h200);
        wait_first_out("s4_first", 32'h200);

        // Request-ready toggling: address held while stalled, no dup/skip
        lat = 1;
        apply_reset();
        d_ready = 1'b1;
        exp_req = '0; exp_out = '0; prev_v = 1'b0; prev_r = 1'b1; prev_ra = '0;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) @(negedge clk);
            mem_i_req_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_v && !prev_r) chk("s5_hold", 64'(mem_i_ra), 64'(prev_ra));
            if (mem_i_req_valid && mem_i_req_ready) begin
                chk("s5_req_seq", 64'(mem_i_ra), 64'(exp_req));
                exp_req += 32'h4;
            end
            if (f_valid) begin
                chk("s5_out_pc", 64'(pc), 64'(exp_out));
                chk("s5_out_instr", 64'(instr), 64'(instr_of(exp_out)));
                exp_out += 32'h4;
            end
            prev_v = mem_i_req_valid; prev_r = mem_i_req_ready; prev_ra = mem_i_ra;
        end
        chk("s5_progress", 64'(exp_out > 32'h10), 64'd1);

        // Reset in the middle of a stream with three entries filled
        lat = 1;
        apply_reset();
        repeat (4) @(negedge clk); #1;
        chk("s6_pre_fv", 64'(f_valid), 64'd1);
        chk("s6_pre_full", 64'(mem_i_req_valid), 64'd0);
        reset = 1'b1; #1;
        chk("s6_in_rst_req", 64'(mem_i_req_valid), 64'd0);
        chk("s6_in_rst_fv", 64'(f_valid), 64'd0);
        @(negedge clk); #1;
        chk("s6_post_fv", 64'(f_valid), 64'd0);
        chk("s6_post_req", 64'(mem_i_req_valid), 64'd0);
        chk("s6_post_instr", 64'(instr), 64'd0);
        reset = 1'b0; d_ready = 1'b1; #1;
        chk("s6_restart_req", 64'(mem_i_req_valid), 64'd1);
        chk("s6_restart_ra", 64'(mem_i_ra), 64'h0);
        wait_first_out("s6_first", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
